// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a byte stream into 32-bit words and writes them into the instruction RAM.
// The trailing XOR checksum byte and the error flag exist only when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter int ADDR_WIDTH = 7,
   parameter int DEPTH      = 128
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  error
);

   localparam logic [ADDR_WIDTH:0] MAX_N = (ADDR_WIDTH+1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH:0]   n_q, n_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic [ADDR_WIDTH:0]   n_clamp;
   logic [1:0]            bidx_q, bidx_d;
   logic [31:0]           word_q, word_d;
   logic                  byte_ready_q, byte_ready_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic                  accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_d;
   logic                  error_q, error_d;
`endif

   assign accept  = byte_valid && byte_ready_q;
   assign n_clamp = (word_count > MAX_N) ? MAX_N : word_count;

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      cnt_d       = cnt_q;
      bidx_d      = bidx_q;
      word_d      = word_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_d      = csum_q;
      error_d     = error_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               n_d    = n_clamp;
               cnt_d  = '0;
               bidx_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d  = '0;
               error_d = 1'b0;
               state_d = (n_clamp == '0) ? S_CHECK : S_RECV;
`else
               state_d = (n_clamp == '0) ? S_DONE : S_RECV;
`endif
            end
         end
         S_RECV: begin
            if (accept) begin
               // shifting left leaves the first byte of the word in [31:24]
               word_d = {word_q[23:0], byte_data};
               bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_d = csum_q ^ byte_data;
`endif
               if (bidx_q == 2'd3) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end else begin
               state_d = S_RECV;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               error_d = (byte_data != csum_q);
               state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      // outputs are decoded from the next state so they line up with the registered state
      byte_ready_d = (state_d == S_RECV) || (state_d == S_CHECK);
      mem_we_d     = (state_d == S_WRITE);
      cpu_hold_d   = (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHECK);
      done_d       = (state_d == S_DONE);
      if (state_d == S_WRITE) begin
         mem_addr_d  = cnt_q[ADDR_WIDTH-1:0];
         mem_wdata_d = word_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         n_q          <= '0;
         cnt_q        <= '0;
         bidx_q       <= '0;
         word_q       <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_hold_q   <= 1'b0;
         done_q       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= '0;
         error_q      <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         bidx_q       <= bidx_d;
         word_q       <= word_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
         error_q      <= error_d;
`endif
      end
   end

   assign byte_ready = byte_ready_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_hold   = cpu_hold_q;
   assign done       = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign error      = error_q;
`else
   assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed and randomized sessions for imem_loader against a word-list model.
module tb_imem_loader;

   localparam int AW    = 7;
   localparam int DEPTH = 128;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CS = 1;
`else
   localparam int CS = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   word_count;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;

   int n_cmp  = 0;
   int n_err  = 0;
   int cyc    = 0;
   int wr_cnt = 0;
   int n_exp  = 0;
   int idx    = 0;

   logic [31:0] exp_words [DEPTH];
   logic [31:0] prog [8] = '{32'h10100000, 32'h10200000, 32'h10300008, 32'h20231000,
                             32'h30210001, 32'h5030FFFD, 32'h40010000, 32'h90000000};

   imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .word_count(word_count),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] stream_byte(input int j, input logic [7:0] cs);
      if (j < 4 * n_exp) return 8'(exp_words[j / 4] >> (24 - 8 * (j % 4)));
      return cs;
   endfunction

   // every write must be the next expected word, after exactly its four bytes
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         check("write_in_range", (wr_cnt < n_exp) ? 32'd1 : 32'd0, 32'd1);
         check("write_addr", 32'(mem_addr), 32'(wr_cnt));
         check("write_data", mem_wdata, exp_words[wr_cnt % DEPTH]);
         check("write_after_4th_byte", 32'(idx), 32'(4 * (wr_cnt + 1)));
         wr_cnt++;
      end
   end

   task automatic run_session(input int n_req, input int fill, input int mode,
                              input int abort_at, input int start_at, input bit bad_cs);
      int n, len, t0, dcyc, budget;
      logic [7:0] cs;
      n      = (n_req > DEPTH) ? DEPTH : n_req;
      n_exp  = n;
      wr_cnt = 0;
      idx    = 0;
      for (int i = 0; i < n; i++)
         exp_words[i] = (fill == 0) ? $urandom : (fill == 1) ? prog[i % 8] : 32'h01020304;
      cs = 8'h00;
      for (int j = 0; j < 4 * n; j++) cs = cs ^ stream_byte(j, 8'h00);
      if (bad_cs) cs = cs ^ 8'h01;
      len = 4 * n + CS;

      @(posedge clk); #1;
      start      = 1'b1;
      word_count = n_req[AW:0];
      byte_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      t0    = cyc;

      budget = 0;
      while (idx < len && budget < 4000) begin
         if (abort_at >= 0 && idx == abort_at) break;
         start      = (idx == start_at);
         byte_valid = (mode == 0) ? 1'b1 : (mode == 1) ? budget[0] : 1'($urandom_range(0, 1));
         byte_data  = stream_byte(idx, cs);
         @(negedge clk);
         if (budget == 0) begin
            check("cpu_hold_rise", cpu_hold, 1);
            check("done_cleared", done, 0);
            check("error_cleared", error, 0);
         end
         if (byte_valid && byte_ready) idx++;
         budget++;
         @(posedge clk); #1;
      end
      start      = 1'b0;
      byte_valid = 1'b0;

      if (abort_at >= 0) begin
         reset = 1'b0;
         @(negedge clk);
         check("rst_byte_ready", byte_ready, 0);
         check("rst_mem_we", mem_we, 0);
         check("rst_mem_addr", 32'(mem_addr), 0);
         check("rst_mem_wdata", mem_wdata, 0);
         check("rst_cpu_hold", cpu_hold, 0);
         check("rst_done", done, 0);
         check("rst_error", error, 0);
         check("rst_words_kept", 32'(wr_cnt), 32'(abort_at / 4));
         @(posedge clk); #1;
         reset = 1'b1;
         return;
      end

      check("bytes_accepted", 32'(idx), 32'(len));
      dcyc = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            dcyc = cyc;
            break;
         end
      end
      check("done_set", done, 1);
      check("cpu_hold_low", cpu_hold, 0);
      check("byte_ready_low", byte_ready, 0);
      check("write_count", 32'(wr_cnt), 32'(n));
      check("error_flag", error, (CS == 1 && bad_cs) ? 32'd1 : 32'd0);
      if (n > 0) check("addr_holds_last", 32'(mem_addr), 32'(n - 1));
      if (mode == 0) check("done_latency", 32'(dcyc - t0), 32'(5 * n + CS));
   endtask

   initial begin
      reset      = 1'b0;
      start      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      word_count = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_byte_ready", byte_ready, 0);
      check("reset_mem_we", mem_we, 0);
      check("reset_mem_addr", 32'(mem_addr), 0);
      check("reset_mem_wdata", mem_wdata, 0);
      check("reset_cpu_hold", cpu_hold, 0);
      check("reset_done", done, 0);
      check("reset_error", error, 0);
      @(posedge clk); #1;
      reset = 1'b1;

      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("idle_no_ready", byte_ready, 0);
         check("idle_no_write", mem_we, 0);
      end
      byte_valid = 1'b0;

      run_session(8, 1, 0, -1, -1, 1'b0);
      run_session(8, 1, 1, -1, -1, 1'b0);
      run_session(200, 0, 2, -1, -1, 1'b0);
      run_session(0, 0, 0, -1, -1, 1'b0);
      run_session(5, 0, 0, 14, -1, 1'b0);
      run_session(4, 0, 2, -1, -1, 1'b0);
      run_session(1, 2, 0, -1, -1, 1'b0);
      run_session(1, 2, 0, -1, -1, 1'b1);
      run_session(6, 0, 0, -1, 6, 1'b0);
      for (int r = 0; r < 3; r++)
         run_session($urandom_range(1, 10), 0, 2, -1, -1, 1'($urandom_range(0, 1)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader for the instruction memory: accepts a byte stream over a valid/ready handshake, packs four bytes into each 32-bit instruction word, and writes the words into the instruction block RAM through its write port (`wea`/`addra`/`dina`) starting at address 0. While loading, it holds the processor out of execution, then signals completion. It is the write-side counterpart of the read-only instruction fetch path and sits between a host link (UART/JTAG byte bridge) and the `blk_mem` instruction RAM.

## Interface
- `ADDR_WIDTH`, 7, instruction RAM address width; matches `PC[6:0]` indexing.
- `DEPTH`, 128, number of 32-bit words in the RAM (2^ADDR_WIDTH).
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  reset, asynchronous, active-low.
- `start`  input  1  one-cycle pulse that begins a load session; sampled only in IDLE or DONE.
- `word_count`  input  ADDR_WIDTH+1  number of words to load; latched on the accepted `start`.
- `byte_valid`  input  1  `byte_data` is valid.
- `byte_data`  input  8  stream byte.
- `byte_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  RAM write enable (to `wea`).
- `mem_addr`  output  ADDR_WIDTH  RAM word address (to `addra`).
- `mem_wdata`  output  32  RAM write data (to `dina`).
- `cpu_hold`  output  1  high while a session is active; the processor must not fetch.
- `done`  output  1  high after a session completes, until the next accepted `start` or reset.
- `error`  output  1  checksum mismatch flag (see Configuration).

## Operation
- States: IDLE, RECV, WRITE, CHECK, DONE.
- IDLE: `start` -> latch `min(word_count, DEPTH)` as N, clear address, byte index, and checksum. N=0 -> CHECK if the checksum is enabled, otherwise DONE. Else -> RECV.
- RECV: `byte_ready`=1. Each handshake (`byte_valid && byte_ready`) places the byte big-endian: byte 0 -> [31:24], byte 1 -> [23:16], byte 2 -> [15:8], byte 3 -> [7:0]. The 4th byte -> WRITE.
- WRITE: exactly one cycle with `mem_we`=1, `mem_addr`=current address, `mem_wdata`=assembled word. `byte_ready`=0. Address is incremented afterwards. If the written word was word N-1 -> CHECK or DONE, else -> RECV.
- CHECK: `byte_ready`=1. Accepts one byte, compares it with the XOR of all data bytes, sets `error` on mismatch, then -> DONE.
- DONE: `done`=1, `cpu_hold`=0. `start` begins a new session (`done` and `error` clear).
- `start` in RECV/WRITE/CHECK is ignored.
- Bytes offered in IDLE/DONE are not accepted (`byte_ready`=0).
- Address never wraps: N is clamped, so the maximum address written is DEPTH-1.
- Reset mid-session: returns to IDLE immediately and discards the partial word. Words already written stay in RAM.

## Timing
- Reset values: `byte_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_hold`=0, `done`=0, `error`=0, state IDLE.
- `cpu_hold` rises the cycle after the accepted `start` and falls on entry to DONE.
- Minimum of 5 cycles per word: 4 byte cycles plus 1 WRITE cycle. Stalls on `byte_valid`=0 add cycles with no state change.
- `mem_addr`/`mem_wdata` are registered outputs and hold their last values outside WRITE.
- `done` rises the cycle after the last WRITE, or after the checksum byte.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: CHECK state is present. One trailing checksum byte (XOR of all 4N data bytes, 0x00 when N=0) is consumed, and `error` reports a mismatch.
- Not defined: CHECK state and checksum logic are removed. WRITE of the last word goes directly to DONE, and `error` is constant 0.

## Test plan
- N=8, stream the summation program bytes (word 0 = 0x10100000 …, word 7 = 0x90000000) with `byte_valid` held high -> eight single-cycle `mem_we` pulses at addresses 0..7 with the exact words, `done` high 41 cycles after `start`, and `cpu_hold` low again.
- Same stream with `byte_valid` toggling every other cycle -> identical RAM contents, and no write until each word's 4th byte is accepted.
- `word_count`=200 -> exactly 128 writes, last at address 127, with no wrap to 0. `word_count`=0 -> no writes, and `done` is set (checksum byte 0x00 is needed if enabled).
- `reset` asserted after 2 bytes of word 3 -> all outputs return to reset values, and no write occurs at address 3. A new session then restarts at address 0.
- With `IMEM_LOADER_CHECKSUM_EN`, N=1, data 0x01020304, checksum 0x04 -> `error`=0. Checksum 0x05 -> `error`=1, and `done`=1 in both cases.
- `start` pulsed during RECV -> ignored, and the address sequence is unchanged.
